// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file with mtime/mtimecmp timer and fixed-priority interrupt selection; CSR_VECTORED_EN enables vectored mtvec mode.
// Reads, take_irq_o and irq_cause_o are combinational from registers; writes and strobes land at the clk_i edge; never stalls.
module csr_irq_unit #(
  parameter int NIRQ     = 4,
  parameter int XLEN     = 64,
  parameter int TICK_DIV = 25
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [11:0]     cadr_i,
  input  logic            coe_i,
  input  logic            cwe_i,
  input  logic [XLEN-1:0] cdat_i,
  output logic [XLEN-1:0] cdat_o,
  output logic            cvalid_o,
  input  logic [NIRQ-1:0] irq_i,
  input  logic            trap_i,
  input  logic [3:0]      cause_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            irq_ack_i,
  input  logic            mret_i,
  input  logic            retire_i,
  output logic            take_irq_o,
  output logic [4:0]      irq_cause_o,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] ivec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o,
  output logic            mpie_o
);
  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [1:0]      MXL       = (XLEN == 64) ? 2'd2 : 2'd1;
  localparam logic [XLEN-1:0] MISA_VAL  = {MXL, {(XLEN-11){1'b0}}, 9'h100};
  localparam logic [XLEN-1:0] MTVEC_RST = XLEN'(64'hFFFF_FFFF_FFFF_FE00);

  logic            status_mie_q, status_mie_d, status_mpie_q, status_mpie_d;
  logic            mtie_q, mtie_d;
  logic [NIRQ-1:0] irqen_q, irqen_d, sync1_q, sync2_q;
  logic [XLEN-1:0] mcause_q, mcause_d, mepc_q, mepc_d, mscratch_q, mscratch_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d, mtime_q, mtime_d;
  logic [XLEN-1:0] mtimecmp_q, mtimecmp_d, mtvec_q, mtvec_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            tick, tmr_pend, timer_act;
  logic [NIRQ-1:0] irq_pend;
  logic [XLEN-1:0] rd_val, mstatus_v, mie_v, mip_v;

  assign tmr_pend   = mtime_q >= mtimecmp_q;
  assign timer_act  = tmr_pend & mtie_q;
  assign irq_pend   = sync2_q & irqen_q;
  assign take_irq_o = status_mie_q & ((|irq_pend) | timer_act);
  assign mtvec_o    = mtvec_q & ~(XLEN'(3));
  assign mepc_o     = mepc_q;
  assign mie_o      = status_mie_q;
  assign mpie_o     = status_mpie_q;

  // Lowest channel index wins; timer only when no channel is pending.
  always_comb begin
    irq_cause_o = 5'd0;
    if (timer_act) irq_cause_o = 5'd7;
    for (int k = NIRQ - 1; k >= 0; k--) begin
      if (irq_pend[k]) irq_cause_o = 5'(16 + k);
    end
  end

`ifdef CSR_VECTORED_EN
  assign ivec_o = mtvec_q[0] ? mtvec_o + XLEN'({irq_cause_o, 2'b00}) : mtvec_o;
`else
  assign ivec_o = mtvec_o;
`endif

  always_comb begin
    mstatus_v        = '0;
    mstatus_v[3]     = status_mie_q;
    mstatus_v[7]     = status_mpie_q;
    mstatus_v[12:11] = 2'b11;
    mie_v            = '0;
    mie_v[7]         = mtie_q;
    mie_v[16 +: NIRQ] = irqen_q;
    mip_v            = '0;
    mip_v[7]         = tmr_pend;
    mip_v[16 +: NIRQ] = sync2_q;
    cvalid_o         = 1'b1;
    rd_val           = '0;
    case (cadr_i)
      12'hF10: rd_val = MISA_VAL;
      12'hF14: rd_val = '0;
      12'h300: rd_val = mstatus_v;
      12'h304: rd_val = mie_v;
      12'h305: rd_val = mtvec_q;
      12'h340: rd_val = mscratch_q;
      12'h341: rd_val = mepc_q;
      12'h342: rd_val = mcause_q;
      12'h344: rd_val = mip_v;
      12'hF00: rd_val = mcycle_q;
      12'hF01: rd_val = mtime_q;
      12'hF02: rd_val = minstret_q;
      12'h7C0: rd_val = mtimecmp_q;
      default: cvalid_o = 1'b0;
    endcase
    cdat_o = (coe_i && cvalid_o) ? rd_val : '0;
  end

  always_comb begin
    status_mie_d  = status_mie_q;
    status_mpie_d = status_mpie_q;
    mtie_d        = mtie_q;
    irqen_d       = irqen_q;
    mcause_d      = mcause_q;
    mepc_d        = mepc_q;
    mscratch_d    = mscratch_q;
    mtimecmp_d    = mtimecmp_q;
    mtvec_d       = mtvec_q;
    tick          = (presc_q == PW'(TICK_DIV - 1));
    presc_d       = tick ? '0 : presc_q + 1'b1;
    mtime_d       = mtime_q + XLEN'(tick);
    mcycle_d      = mcycle_q + 1'b1;
    minstret_d    = minstret_q + XLEN'(retire_i);
    if (cwe_i) begin
      case (cadr_i)
        12'h304: begin
          mtie_d  = cdat_i[7];
          irqen_d = cdat_i[16 +: NIRQ];
        end
`ifdef CSR_VECTORED_EN
        12'h305: mtvec_d = {cdat_i[XLEN-1:2], 1'b0, cdat_i[0]};
`else
        12'h305: mtvec_d = {cdat_i[XLEN-1:2], 2'b00};
`endif
        12'h340: mscratch_d = cdat_i;
        12'h7C0: mtimecmp_d = cdat_i;
        default: ;
      endcase
    end
    // Trap/interrupt entry owns mepc, mcause and the status bits outright that cycle.
    if (trap_i) begin
      mepc_d        = epc_i;
      mcause_d      = XLEN'(cause_i);
      status_mpie_d = status_mie_q;
      status_mie_d  = 1'b0;
    end else if (irq_ack_i) begin
      mepc_d        = epc_i;
      mcause_d      = {1'b1, {(XLEN-6){1'b0}}, irq_cause_o};
      status_mpie_d = status_mie_q;
      status_mie_d  = 1'b0;
    end else begin
      if (mret_i) begin
        status_mie_d  = status_mpie_q;
        status_mpie_d = 1'b1;
      end else if (cwe_i && cadr_i == 12'h300) begin
        status_mie_d  = cdat_i[3];
        status_mpie_d = cdat_i[7];
      end
      if (cwe_i && cadr_i == 12'h341) mepc_d = {cdat_i[XLEN-1:2], 2'b00};
      if (cwe_i && cadr_i == 12'h342) mcause_d = cdat_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      status_mie_q  <= 1'b0;
      status_mpie_q <= 1'b0;
      mtie_q        <= 1'b0;
      irqen_q       <= '0;
      mcause_q      <= '0;
      mepc_q        <= '0;
      mscratch_q    <= '0;
      mcycle_q      <= '0;
      minstret_q    <= '0;
      mtime_q       <= '0;
      presc_q       <= '0;
      mtimecmp_q    <= '1;
      mtvec_q       <= MTVEC_RST;
      sync1_q       <= '0;
      sync2_q       <= '0;
    end else begin
      status_mie_q  <= status_mie_d;
      status_mpie_q <= status_mpie_d;
      mtie_q        <= mtie_d;
      irqen_q       <= irqen_d;
      mcause_q      <= mcause_d;
      mepc_q        <= mepc_d;
      mscratch_q    <= mscratch_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
      mtime_q       <= mtime_d;
      presc_q       <= presc_d;
      mtimecmp_q    <= mtimecmp_d;
      mtvec_q       <= mtvec_d;
      sync1_q       <= irq_i;
      sync2_q       <= sync1_q;
    end
  end
endmodule
